muldiv_iter_unit: RTL
=====================

# muldiv_iter_unit

Parametrised RV M-extension execute unit with a valid/ready handshake and variable latency. It replaces the fixed-latency pipelined multiplier/divider. It takes one operation at a time from the issue stage and returns a tagged result to writeback. Multiplication is multi-cycle with a configurable cycle count. Division is a radix-2 restoring iteration with single-cycle early-out for divide-by-zero and signed overflow, and flush/abort support.

## Interface
- XLEN, 32: operand/result width (32 or 64)
- MUL_CYCLES, 2: cycles spent in MUL state (1..4)
- TAG_W, 5: width of destination tag carried with the op
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- valid_i  in  1  operation offered
- ready_o  out  1  unit can accept this cycle
- op_a_i  in  XLEN  rs1 value
- op_b_i  in  XLEN  rs2 value
- funct3_i  in  3  M-ext funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- tag_i  in  TAG_W  destination tag
- flush_i  in  1  abort in-flight op
- valid_o  out  1  result available
- ready_i  in  1  consumer takes result
- result_o  out  XLEN  result
- tag_o  out  TAG_W  tag of result
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept = valid_i & ready_o & ~flush_i.
- ready_o = ~flush_i & (IDLE | (DONE & ready_i)).
- On accept, latch the operands, funct3 and tag.
- MUL family: go to MUL, count down from MUL_CYCLES, then go to DONE.
  - Operand extension to XLEN+1 bits: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - Result: MUL = product[XLEN-1:0]; others = product[2XLEN-1:XLEN].
- DIV family special cases resolve at accept and go straight to DONE:
  - b==0: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (DIV/REM, a==100..0, b==all-ones): DIV → a; REM → 0.
- DIV family normal case: go to DIV and perform XLEN restoring iterations on magnitudes.
  - Remainder register is XLEN+1 bits; quotient register is XLEN bits; one quotient bit per cycle, MSB first.
  - After iteration XLEN, go to DONE.
  - Signed fixup in DONE: negate the quotient if the operand signs differ; the remainder takes the sign of a.
- DONE: valid_o=1 and result_o/tag_o are stable until ready_i.
  - valid_o & ready_i with a new accept in the same cycle: start the next op, with no idle bubble.
  - valid_o & ready_i without a new accept: go to IDLE.
- Flush: any state goes to IDLE next edge. It drops the pending result (valid_o falls next cycle). No accept occurs in a flush cycle.
- Reset mid-operation: immediate return to IDLE; all state cleared.

## Timing
- Reset values:
  - ready_o=1 (while flush_i=0); valid_o=0; busy_o=0; result_o=0; tag_o=0.
  - All internal registers 0.
- Latency counts cycles from the accept edge to the first cycle of valid_o:
  - MUL family: MUL_CYCLES+1.
  - DIV family, normal case: XLEN+1.
  - DIV family, special case: 1.
- Back-to-back throughput: one op per (latency) cycles, with no extra bubble when ready_i is held high.
- Backpressure: with ready_i low, the unit holds DONE indefinitely, and result_o/tag_o must not change.
- Only one op is in flight at a time. valid_i is ignored while ready_o=0.
- result_o and tag_o are registered or derived only from registered state; there is no combinational path from op_*_i to result_o.
- There is a combinational path from ready_i to ready_o.

## Test plan
- XLEN=32, MUL_CYCLES=2.
  - Input: MULH a=0x80000000, b=0x80000000.
  - Expected: result 0x40000000; valid_o in the 3rd cycle after accept; tag echoed.
- MULHSU a=0xFFFFFFFF (−1), b=0xFFFFFFFF.
  - Expected: result 0xFFFFFFFF.
  - Sweep 10k random MUL/MULH/MULHSU/MULHU ops against the reference model.
- DIV a=0xFFFFFFF9 (−7), b=2.
  - Expected: quotient 0xFFFFFFFD (−3); valid_o at cycle 33.
- REM a=−7, b=2.
  - Expected: remainder 0xFFFFFFFF (−1).
- Special cases, each with a 1-cycle latency:
  - DIVU a=5, b=0 → 0xFFFFFFFF.
  - REM a=5, b=0 → 5.
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Backpressure and flush:
  - DIV with ready_i low for 10 cycles in DONE: result and tag stay stable, and no accept occurs.
  - Then ready_i high with valid_i: a back-to-back MUL is accepted in the same cycle.
  - flush_i in DIV iteration 5: valid_o never rises, and the unit is IDLE with ready_o=1 the next cycle.
  - rst_ni pulse mid-MUL: all outputs at reset values immediately.
- XLEN=64, MUL_CYCLES=4 random regression:
  - Latencies are 5 cycles (MUL family), 65 cycles (DIV family) and 1 cycle (special cases).
  - All results match the reference model.

Source files
------------

// File: rtl/muldiv_iter_unit_if.sv
// Issue/writeback handshake bundle for the iterative M-extension unit.
// Signal names are from the unit's point of view (slave side).
interface muldiv_iter_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [XLEN-1:0]  op_a_i;
  logic [XLEN-1:0]  op_b_i;
  logic [2:0]       funct3_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  modport slave (
    input  valid_i, op_a_i, op_b_i, funct3_i, tag_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, busy_o
  );

  modport master (
    output valid_i, op_a_i, op_b_i, funct3_i, tag_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, busy_o
  );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension unit: multi-cycle multiply, radix-2 restoring divide,
// one op in flight, tagged result held in DONE until the consumer takes it.
//
// state  | meaning
// IDLE   | no op in flight, ready for a new op
// MUL    | multiply in progress, r_cnt cycles remaining
// DIV    | restoring division, r_cnt quotient bits remaining
// DONE   | result valid, held until ready_i
module muldiv_iter_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  muldiv_iter_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_start;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_result;
  logic [XLEN:0]    r_rem;
  logic [2:0]       r_funct3;
  logic [TAG_W-1:0] r_tag;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_ready;
  logic             w_accept;
  logic             w_is_div;
  logic             w_div_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_special;
  logic             w_last;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic [XLEN-1:0]  w_special_res;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  logic [XLEN:0]    w_rem_sh;
  logic [XLEN:0]    w_diff;
  logic             w_ge;
  logic [XLEN:0]    w_rem_nx;
  logic [XLEN-1:0]  w_quo_nx;
  logic [XLEN-1:0]  w_quo_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_div_res;
  logic [XLEN-1:0]  w_fin_res;

  // Accept side, evaluated on the raw inputs
  assign w_ready   = ~bus.flush_i & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.ready_i));
  assign w_accept  = bus.valid_i & w_ready;
  assign w_is_div  = bus.funct3_i[2];
  assign w_div_sgn = ~bus.funct3_i[0];
  assign w_a_neg   = w_div_sgn & bus.op_a_i[XLEN-1];
  assign w_b_neg   = w_div_sgn & bus.op_b_i[XLEN-1];
  assign w_a_mag   = w_a_neg ? -bus.op_a_i : bus.op_a_i;
  assign w_b_mag   = w_b_neg ? -bus.op_b_i : bus.op_b_i;
  assign w_b_zero  = (bus.op_b_i == '0);
  assign w_ovf     = w_div_sgn & (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b_i);
  assign w_special = w_is_div & (w_b_zero | w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
    else          w_special_res = bus.funct3_i[1] ? '0 : bus.op_a_i;
  end

  always_comb begin
    w_start = S_MUL;
    if (w_is_div) w_start = w_special ? S_DONE : S_DIV;
  end

  assign w_last = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:       if (w_accept) w_state_nxt = w_start;
        S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
        S_DONE:       if (bus.ready_i) w_state_nxt = w_accept ? w_start : S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Multiply from latched operands; MULHSU leaves rs2 unsigned, MULHU both
  assign w_a_sgn   = (r_funct3[1:0] != 2'b11);
  assign w_b_sgn   = ~r_funct3[1];
  assign w_a_ext   = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
  assign w_b_ext   = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // One restoring step per cycle; dividend bits shift out of the quotient register
  assign w_rem_sh  = (r_rem << 1) | {{XLEN{1'b0}}, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nx  = w_ge ? w_diff : w_rem_sh;
  assign w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
  assign w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_neg_r ? -w_rem_nx[XLEN-1:0] : w_rem_nx[XLEN-1:0];
  assign w_div_res = r_funct3[1] ? w_rem_fix : w_quo_fix;
  assign w_fin_res = r_funct3[2] ? w_div_res : w_mul_res;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_funct3 <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.op_a_i;
      r_b      <= w_is_div ? w_b_mag : bus.op_b_i;
      r_quo    <= w_a_mag;
      r_rem    <= '0;
      r_funct3 <= bus.funct3_i;
      r_tag    <= bus.tag_i;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (!w_is_div)     r_cnt <= CNT_W'(MUL_CYCLES);
      else if (w_special) r_cnt <= '0;
      else               r_cnt <= CNT_W'(XLEN);
      if (w_special) r_result <= w_special_res;
    end else if (!bus.flush_i && (r_state == S_MUL || r_state == S_DIV)) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == S_DIV) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
      end
      if (w_last) r_result <= w_fin_res;
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.valid_o  = (r_state == S_DONE);
  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.result_o = r_result;
  assign bus.tag_o    = r_tag;
endmodule
